// File: rtl/btn_capture_pkg.sv
// Shared constants and helpers for the button capture bank.
// Imported by the debouncer and by the bank top.
package btn_capture_pkg;

  localparam int DB_CYCLES_BOARD = 500000;
  localparam int DB_CYCLES_SIM   = 4;

  // A width of at least one bit keeps counters and selects legal for small sizes.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus stability-count debouncer for one raw button.
// rise is high in the cycle whose closing edge moves level from 0 to 1.
module sync_debounce
  import btn_capture_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_SIM
) (
  input  logic CLK50M,
  input  logic reset,
  input  logic noisy,
  output logic level,
  output logic rise
);

  localparam int               CNT_W    = clog2_min1(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             meta_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync_p1 != level) && (cnt == CNT_LAST);
  assign rise   = accept && sync_p1;

  always_ff @(posedge CLK50M) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
    end else begin
      // synchronizer stage boundary: raw -> meta_p0 -> sync_p1
      meta_p0 <= noisy;
      sync_p1 <= meta_p0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_capture_bank.sv
// Debounced capture of a switch word into a shift-history bank, with clear,
// occupancy count and a combinational LED view of one selected entry.
module btn_capture_bank
  import btn_capture_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int DB_CYCLES = DB_CYCLES_BOARD,
  parameter int SEL_W     = clog2_min1(DEPTH)
) (
  input  logic             CLK50M,
  input  logic             reset,
  input  logic             A_noisy,
  input  logic             C_noisy,
  input  logic [WIDTH-1:0] binary,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] led,
  output logic [SEL_W:0]   count,
  output logic             full,
  output logic             capture_pulse
);

  localparam logic [SEL_W:0] DEPTH_C = (SEL_W + 1)'(DEPTH);

  logic             cap_ev;
  logic             clr_ev;
  logic             a_level;
  logic             c_level;
  logic             levels_unused;
  logic [WIDTH-1:0] bank [DEPTH];
  logic [SEL_W:0]   sel_ext;

  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .CLK50M (CLK50M),
    .reset  (reset),
    .noisy  (A_noisy),
    .level  (a_level),
    .rise   (cap_ev)
  );

  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (
    .CLK50M (CLK50M),
    .reset  (reset),
    .noisy  (C_noisy),
    .level  (c_level),
    .rise   (clr_ev)
  );

  // Only the rising edges drive the bank; the levels themselves are not needed here.
  assign levels_unused = a_level ^ c_level;

  always_ff @(posedge CLK50M) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      count         <= '0;
      capture_pulse <= 1'b0;
    end else begin
      capture_pulse <= 1'b0;
      if (clr_ev) begin
        for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        count <= '0;
      end else if (cap_ev) begin
        bank[0] <= binary;
        for (int i = 1; i < DEPTH; i++) bank[i] <= bank[i-1];
        if (count != DEPTH_C) count <= count + 1'b1;
        capture_pulse <= 1'b1;
      end
    end
  end

  assign full    = (count == DEPTH_C);
  assign sel_ext = {1'b0, sel};

  // Explicit match keeps out-of-range selects (non-power-of-2 DEPTH) at zero.
  always_comb begin
    led = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_ext == (SEL_W + 1)'(i)) led = bank[i];
    end
  end

endmodule

// File: tb/tb_btn_capture_bank.sv
// Directed bench for btn_capture_bank with a short debounce window.
module tb_btn_capture_bank;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int DBC   = 4;

  logic       clk;
  logic       reset;
  logic       A_noisy;
  logic       C_noisy;
  logic [3:0] binary;
  logic [1:0] sel;
  logic [3:0] led;
  logic [2:0] count;
  logic       full;
  logic       capture_pulse;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0] bin;
    logic [2:0] cnt;
    logic       full;
    logic [3:0] led0;
  } press_vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] led;
  } rd_vec_t;

  press_vec_t pv [5];
  rd_vec_t    rv [4];

  btn_capture_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DB_CYCLES(DBC), .SEL_W(2)
  ) dut (
    .CLK50M        (clk),
    .reset         (reset),
    .A_noisy       (A_noisy),
    .C_noisy       (C_noisy),
    .binary        (binary),
    .sel           (sel),
    .led           (led),
    .count         (count),
    .full          (full),
    .capture_pulse (capture_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  // Press A for 8 cycles then release for 8; returns the number of pulses seen.
  task automatic press(input logic [3:0] v, output int npulse);
    npulse  = 0;
    binary  = v;
    A_noisy = 1'b1;
    repeat (8) begin
      step();
      if (capture_pulse) npulse++;
    end
    A_noisy = 1'b0;
    repeat (8) begin
      step();
      if (capture_pulse) npulse++;
    end
  endtask

  initial begin
    int np;
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    A_noisy = 1'b0;
    C_noisy = 1'b0;
    binary  = 4'h0;
    sel     = 2'd0;

    pv[0] = '{bin: 4'h1, cnt: 3'd1, full: 1'b0, led0: 4'h1};
    pv[1] = '{bin: 4'h2, cnt: 3'd2, full: 1'b0, led0: 4'h2};
    pv[2] = '{bin: 4'h3, cnt: 3'd3, full: 1'b0, led0: 4'h3};
    pv[3] = '{bin: 4'h4, cnt: 3'd4, full: 1'b1, led0: 4'h4};
    pv[4] = '{bin: 4'h5, cnt: 3'd4, full: 1'b1, led0: 4'h5};
    rv[0] = '{sel: 2'd0, led: 4'h5};
    rv[1] = '{sel: 2'd1, led: 4'h4};
    rv[2] = '{sel: 2'd2, led: 4'h3};
    rv[3] = '{sel: 2'd3, led: 4'h2};

    // Reset state
    do_reset(3);
    chk("reset_led", led, 4'h0);
    chk("reset_count", count, 3'd0);
    chk("reset_full", full, 1'b0);
    chk("reset_pulse", capture_pulse, 1'b0);

    // First capture: pulse after the fifth edge following the first sample, held long
    binary  = 4'hA;
    A_noisy = 1'b1;
    repeat (5) step();
    chk("cap_pulse_early", capture_pulse, 1'b0);
    step();
    chk("cap_pulse_on", capture_pulse, 1'b1);
    chk("cap_led", led, 4'hA);
    chk("cap_count", count, 3'd1);
    step();
    chk("cap_pulse_off", capture_pulse, 1'b0);
    np = 0;
    repeat (20) begin
      step();
      if (capture_pulse) np++;
    end
    chk("held_no_repeat", np, 0);
    A_noisy = 1'b0;
    repeat (10) begin
      step();
      if (capture_pulse) np++;
    end
    chk("release_no_event", np, 0);

    // Bounce shorter than the debounce window
    np = 0;
    A_noisy = 1'b1; repeat (2) begin step(); if (capture_pulse) np++; end
    A_noisy = 1'b0; repeat (1) begin step(); if (capture_pulse) np++; end
    A_noisy = 1'b1; repeat (3) begin step(); if (capture_pulse) np++; end
    A_noisy = 1'b0; repeat (10) begin step(); if (capture_pulse) np++; end
    chk("bounce_pulses", np, 0);
    chk("bounce_count", count, 3'd1);
    chk("bounce_led", led, 4'hA);

    // Five presses: saturation and shift ordering
    do_reset(2);
    chk("rst2_count", count, 3'd0);
    for (int i = 0; i < 5; i++) begin
      sel = 2'd0;
      press(pv[i].bin, np);
      chk($sformatf("press%0d_pulses", i), np, 1);
      chk($sformatf("press%0d_count", i), count, pv[i].cnt);
      chk($sformatf("press%0d_full", i), full, pv[i].full);
      chk($sformatf("press%0d_led0", i), led, pv[i].led0);
    end
    for (int i = 0; i < 4; i++) begin
      sel = rv[i].sel;
      #1;
      chk($sformatf("readback_sel%0d", i), led, rv[i].led);
    end

    // Clear and capture arriving together: clear wins
    do_reset(2);
    press(4'h7, np);
    press(4'h9, np);
    sel = 2'd1;
    #1;
    chk("pre_clear_count", count, 3'd2);
    chk("pre_clear_led1", led, 4'h7);
    np = 0;
    A_noisy = 1'b1;
    C_noisy = 1'b1;
    repeat (10) begin step(); if (capture_pulse) np++; end
    A_noisy = 1'b0;
    C_noisy = 1'b0;
    repeat (10) begin step(); if (capture_pulse) np++; end
    chk("clr_cap_pulses", np, 0);
    chk("clr_count", count, 3'd0);
    chk("clr_full", full, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      chk($sformatf("clr_led_sel%0d", i), led, 4'h0);
    end

    // Button held through reset: fresh debounce after release, one capture
    sel     = 2'd0;
    binary  = 4'h6;
    A_noisy = 1'b1;
    do_reset(10);
    chk("rst_hold_count0", count, 3'd0);
    np = 0;
    repeat (4) begin step(); if (capture_pulse) np++; end
    chk("rst_hold_no_early", np, 0);
    repeat (8) begin step(); if (capture_pulse) np++; end
    chk("rst_hold_pulses", np, 1);
    chk("rst_hold_count", count, 3'd1);
    chk("rst_hold_led", led, 4'h6);
    A_noisy = 1'b0;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_capture_bank.md
Name: btn_capture_bank

Overview:
- Parametrised successor to the 4-bit button-clocked LED register.
- Samples a WIDTH-bit switch word into a DEPTH-entry history bank on each debounced press of a capture button; a second button clears the bank.
- Everything runs in the single CLK50M domain; the debounced button is never used as a clock.
- One selected entry drives the board LEDs; occupancy and full status are exported for the vending FSM and status LEDs.

Parameters:
- WIDTH, 4, data/LED width in bits (>=1).
- DEPTH, 4, number of history entries (>=2).
- DB_CYCLES, 500000, consecutive stable CLK50M cycles needed to accept a button level change (10 ms at 50 MHz; >=2).
- SEL_W, $clog2(DEPTH), width of the entry select.

Ports:
- CLK50M  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- A_noisy  in  1  raw capture button, asynchronous, bouncing.
- C_noisy  in  1  raw clear button, asynchronous, bouncing.
- binary  in  WIDTH  switch word, captured on a capture event.
- sel  in  SEL_W  entry shown on led; 0 = newest.
- led  out  WIDTH  contents of entry[sel].
- count  out  SEL_W+1  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- capture_pulse  out  1  one-cycle strobe, high in the cycle a capture is committed.

Behaviour:
- Reset: synchronous, active-high, sampled on the CLK50M rising edge. While reset is high:
  - Synchronizer flops, debounced levels and debounce counters go to 0.
  - All entries, count, full and capture_pulse go to 0.
  - led = 0.
  - Reset overrides every other event in the same cycle.
- Button path (per button):
  - 2-flop synchronizer, giving s.
  - Counter increments each cycle s != db_level and clears when s == db_level.
  - When the counter is at DB_CYCLES-1 and s still differs, db_level takes s and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes db_level.
  - Latency: raw level first sampled at edge t gives a db_level change at edge t+2+DB_CYCLES-1.
- Event detect:
  - cap_ev = db_level_A rising (0->1) in this cycle.
  - clr_ev = db_level_C rising.
  - A release (1->0) produces no event.
- Capture (cap_ev and not clr_ev):
  - entry[0] <= binary sampled at that edge; entry[i] <= entry[i-1] for i = 1..DEPTH-1.
  - entry[DEPTH-1] is discarded.
  - count <= min(count+1, DEPTH), i.e. saturates; full follows.
  - capture_pulse = 1 for exactly that one cycle.
- Clear (clr_ev): all entries 0, count 0, full 0, capture_pulse 0.
- Simultaneous cap_ev and clr_ev: clear wins; no capture, no pulse.
- Capture when full: shift still occurs (oldest entry lost); count stays at DEPTH.
- Output select:
  - led = entry[sel], combinational from the registered bank.
  - sel >= DEPTH (non-power-of-2 DEPTH) gives led = 0.
  - Entries at positions >= count read their cleared value of 0.
- Held button: only one capture per press, however long it is held.
- Reset mid-debounce: the counter is lost; a button still held after reset needs a full DB_CYCLES of stability and then produces a capture (db_level restarts at 0).

Decomposition:
- Package btn_capture_pkg holds:
  - DB_CYCLES_BOARD = 500000.
  - DB_CYCLES_SIM = 4.
  - Function clog2_min1 for select/count widths.
- One sub-module, sync_debounce, instantiated twice.
  - Parameter: DB_CYCLES.
  - Ports: CLK50M, reset, noisy, level, rise.
  - Contains the 2-flop synchronizer, the counter and the rising-edge detector.
- Bank shift, count and output mux live in btn_capture_bank.

Test Plan (WIDTH=4, DEPTH=4, DB_CYCLES=4):
- Reset held 3 cycles with buttons low -> led=0, count=0, full=0, capture_pulse=0.
- binary=4'hA; A_noisy high and held -> capture_pulse high for exactly one cycle, 5 edges after the first sampled high. sel=0 gives led=4'hA, count=1. No further pulses while held.
- A_noisy bounces high 2 cycles / low 1 / high 3 / low -> no capture_pulse, count unchanged.
- Five presses with binary=1,2,3,4,5 -> count=4, full=1 after the 4th press. After the 5th: sel=0..3 gives led=5,4,3,2, and count stays 4.
- Bank holding 2 entries; C_noisy and A_noisy driven high in the same cycle -> no capture_pulse, count=0, led=0 for all sel.
- A_noisy held during reset (reset high for 10 cycles) -> after reset falls, a capture occurs DB_CYCLES+1 edges later, count=1.
